// File: rtl/printer_job_engine.sv
// rtl/printer_job_engine.sv - grant-bus print job engine; optional tray model under PAPER_COUNT_EN
module printer_job_engine #(
  parameter int PAGE_CYCLES = 4,
  parameter int PW          = 4,
  parameter int TRAY_PAGES  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    usingby,
  input  logic [PW-1:0] pages_boss,
  input  logic [PW-1:0] pages_eng,
  input  logic [PW-1:0] pages_boy,
  input  logic          refill,
  output logic          busy,
  output logic [1:0]    cur_user,
  output logic [PW-1:0] pages_left,
  output logic          page_tick,
  output logic          done_boss,
  output logic          done_eng,
  output logic          done_boy,
  output logic          abort,
  output logic          no_paper
);

  localparam int TW = (PAGE_CYCLES > 2) ? $clog2(PAGE_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(PAGE_CYCLES - 1);

  // LOAD is the first busy cycle after the grant is latched; it aligns the
  // first page_tick to PAGE_CYCLES cycles after the load edge.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_PRINT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [1:0]    user_q, user_nxt;
  logic [PW-1:0] left_q, left_nxt;
  logic [TW-1:0] timer_q, timer_nxt;
  logic [PW-1:0] req_pages;
  logic          stall;

  // Job length offered by whichever requester currently holds the grant.
  always_comb begin
    req_pages = '0;
    case (usingby)
      2'b01:   req_pages = pages_boy;
      2'b10:   req_pages = pages_eng;
      2'b11:   req_pages = pages_boss;
      default: req_pages = '0;
    endcase
  end

`ifdef PAPER_COUNT_EN
  localparam int CW = $clog2(TRAY_PAGES + 1);
  logic [CW-1:0] tray_q;

  // Sheets remaining in the tray; a refill overrides a same-cycle page consumption.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tray_q <= CW'(TRAY_PAGES);
    end else if (refill) begin
      tray_q <= CW'(TRAY_PAGES);
    end else if (page_tick) begin
      tray_q <= tray_q - CW'(1);
    end
  end

  assign stall = (state == S_PRINT) && (timer_q == '0) && (tray_q == '0);
`else
  logic unused_cfg;
  assign unused_cfg = &{1'b0, refill, TRAY_PAGES[0]};
  assign stall      = 1'b0;
`endif

  // State and job datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      user_q  <= '0;
      left_q  <= '0;
      timer_q <= '0;
    end else begin
      state   <= state_nxt;
      user_q  <= user_nxt;
      left_q  <= left_nxt;
      timer_q <= timer_nxt;
    end
  end

  // Next-state and output decode; grant removal is seen combinationally so
  // abort lands in the same cycle usingby drops.
  always_comb begin
    state_nxt = state;
    user_nxt  = user_q;
    left_nxt  = left_q;
    timer_nxt = timer_q;
    busy      = 1'b0;
    page_tick = 1'b0;
    abort     = 1'b0;
    done_boss = 1'b0;
    done_eng  = 1'b0;
    done_boy  = 1'b0;
    case (state)
      S_IDLE: begin
        if (usingby != 2'b00) begin
          user_nxt  = usingby;
          left_nxt  = (req_pages == '0) ? PW'(1) : req_pages;
          timer_nxt = '0;
          state_nxt = S_LOAD;
        end
      end
      S_LOAD, S_PRINT: begin
        busy = 1'b1;
        if (usingby == 2'b00) begin
          abort     = 1'b1;
          user_nxt  = '0;
          left_nxt  = '0;
          timer_nxt = '0;
          state_nxt = S_IDLE;
        end else if (state == S_LOAD) begin
          state_nxt = S_PRINT;
        end else if (!stall) begin
          if (timer_q == T_LAST) begin
            page_tick = 1'b1;
            timer_nxt = '0;
            left_nxt  = left_q - PW'(1);
            if (left_q == PW'(1)) begin
              state_nxt = S_DONE;
            end
          end else begin
            timer_nxt = timer_q + TW'(1);
          end
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        done_boy  = (user_q == 2'b01);
        done_eng  = (user_q == 2'b10);
        done_boss = (user_q == 2'b11);
        user_nxt  = '0;
        left_nxt  = '0;
        timer_nxt = '0;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign cur_user   = user_q;
  assign pages_left = left_q;
  assign no_paper   = stall;

endmodule
